// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: drives the PC counter, talks req/ack to instruction
// memory and fills the IF/ID register, handling load-use stalls and redirects.
module fetch_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] prog_count,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] next_pc,
    output logic        pc_write,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] hold_instr, hold_pc, drain_addr;
    logic [31:0] pc_plus4, hold_pc_plus4;

    assign pc_plus4      = prog_count + 32'd4;
    assign hold_pc_plus4 = hold_pc + 32'd4;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (branch_taken) begin
            case (state)
                FETCH:   state_nxt = imem_ack ? FETCH : DRAIN;
                DRAIN:   state_nxt = imem_ack ? FETCH : DRAIN;
                default: state_nxt = FETCH;
            endcase
        end else begin
            case (state)
                FETCH:   if (imem_ack && stall) state_nxt = HOLD;
                HOLD:    if (!stall) state_nxt = FETCH;
                DRAIN:   if (imem_ack) state_nxt = FETCH;
                default: state_nxt = FETCH;
            endcase
        end
    end

    // Request/PC-load controls are purely combinational; gated off while in reset.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = prog_count;
        pc_write  = 1'b0;
        next_pc   = pc_plus4;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                pc_write = imem_ack && !stall;
            end
            HOLD: begin
                if (!stall) begin
                    pc_write = 1'b1;
                    next_pc  = hold_pc_plus4;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
            end
            default: ;
        endcase
        if (branch_taken) begin
            pc_write = 1'b1;
            next_pc  = branch_target;
        end
        if (!reset) begin
            imem_req = 1'b0;
            pc_write = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_id_valid    <= 1'b0;
            if_id_instr    <= '0;
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
            hold_instr     <= '0;
            hold_pc        <= '0;
            drain_addr     <= '0;
        end else if (branch_taken) begin
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            hold_instr  <= '0;
            hold_pc     <= '0;
            // Remember the in-flight address so the request stays stable until its ack.
            if (state == FETCH && !imem_ack) drain_addr <= prog_count;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack && !stall) begin
                        if_id_valid    <= 1'b1;
                        if_id_instr    <= imem_rdata;
                        if_id_pc       <= prog_count;
                        if_id_pc_plus4 <= pc_plus4;
                    end else if (imem_ack) begin
                        hold_instr <= imem_rdata;
                        hold_pc    <= prog_count;
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= '0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_valid    <= 1'b1;
                        if_id_instr    <= hold_instr;
                        if_id_pc       <= hold_pc;
                        if_id_pc_plus4 <= hold_pc_plus4;
                    end
                end
                DRAIN: begin
                    if_id_valid <= 1'b0;
                    if_id_instr <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small PC counter model plus hand-driven memory acks.
module tb_fetch_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] prog_count;
    logic        stall, branch_taken, imem_ack;
    logic [31:0] branch_target, imem_rdata;
    logic        imem_req, pc_write, if_id_valid;
    logic [31:0] imem_addr, next_pc, if_id_instr, if_id_pc, if_id_pc_plus4;
    logic        ld;
    logic [31:0] ld_val;
    int          n_chk = 0, n_pass = 0;

    fetch_stage dut (
        .clock(clock), .reset(reset), .prog_count(prog_count), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .next_pc(next_pc), .pc_write(pc_write),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4)
    );

    always #5 clock = ~clock;

    // PC counter model, with a bench-side preload port.
    always @(posedge clock) begin
        if (ld)            prog_count <= ld_val;
        else if (pc_write) prog_count <= next_pc;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Preload the counter with a cycle in which FETCH neither loads nor bubbles IF/ID.
    task automatic set_pc(input logic [31:0] v);
        @(negedge clock);
        ld = 1'b1; ld_val = v; imem_ack = 1'b0; stall = 1'b1; branch_taken = 1'b0;
        @(posedge clock); #1;
        ld = 1'b0;
    endtask

    task automatic drive(input logic a, input logic s, input logic b,
                         input logic [31:0] tgt, input logic [31:0] rd);
        @(negedge clock);
        imem_ack = a; stall = s; branch_taken = b; branch_target = tgt; imem_rdata = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b0; ld = 1'b0; ld_val = '0; prog_count = '0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        #2;
        chk("rst_valid", {31'd0, if_id_valid}, 0);
        chk("rst_instr", if_id_instr, 0);
        chk("rst_req", {31'd0, imem_req}, 0);
        chk("rst_pcw", {31'd0, pc_write}, 0);
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b1; #1;
        chk("rel_req", {31'd0, imem_req}, 1);

        // Zero-wait memory: one instruction per cycle.
        set_pc(32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h1000 + prog_count);
            chk("zw_addr", imem_addr, 32'(i * 4));
            chk("zw_pcw", {31'd0, pc_write}, 1);
            chk("zw_npc", next_pc, 32'(i * 4 + 4));
            tick();
            chk("zw_instr", if_id_instr, 32'h1000 + 32'(i * 4));
            chk("zw_valid", {31'd0, if_id_valid}, 1);
            chk("zw_pc", if_id_pc, 32'(i * 4));
        end

        // Slow memory at 0x40, stalled on the ack cycle and the one after.
        set_pc(32'h40);
        repeat (2) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            chk("sl_addr", imem_addr, 32'h40);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0BAD0040);
        chk("sl_ack_pcw", {31'd0, pc_write}, 0);
        tick();
        chk("sl_hold_instr", if_id_instr, 32'h100C);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF);
        chk("sl_hold_req", {31'd0, imem_req}, 0);
        chk("sl_hold_pcw", {31'd0, pc_write}, 0);
        tick();
        chk("sl_hold_pc", if_id_pc, 32'hC);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("sl_rel_pcw", {31'd0, pc_write}, 1);
        chk("sl_rel_npc", next_pc, 32'h44);
        tick();
        chk("sl_instr", if_id_instr, 32'h0BAD0040);
        chk("sl_pc", if_id_pc, 32'h40);
        chk("sl_pc4", if_id_pc_plus4, 32'h44);
        chk("sl_valid", {31'd0, if_id_valid}, 1);

        // Redirect while the request to 0x80 is outstanding.
        set_pc(32'h80);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("br_addr0", imem_addr, 32'h80);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'h200, 32'h0);
        chk("br_pcw", {31'd0, pc_write}, 1);
        chk("br_npc", next_pc, 32'h200);
        chk("br_addr1", imem_addr, 32'h80);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF);
        chk("dr_addr", imem_addr, 32'h80);
        chk("dr_req", {31'd0, imem_req}, 1);
        chk("dr_pcw", {31'd0, pc_write}, 0);
        tick();
        chk("dr_valid", {31'd0, if_id_valid}, 0);
        chk("dr_instr", if_id_instr, 0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("br_newaddr", imem_addr, 32'h200);
        chk("br_newreq", {31'd0, imem_req}, 1);

        // Redirect, stall and ack together: redirect wins.
        set_pc(32'h300);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h5555_0300);
        tick();
        chk("bs_pre_valid", {31'd0, if_id_valid}, 1);
        drive(1'b1, 1'b1, 1'b1, 32'h500, 32'h1234_5678);
        chk("bs_pcw", {31'd0, pc_write}, 1);
        chk("bs_npc", next_pc, 32'h500);
        tick();
        chk("bs_valid", {31'd0, if_id_valid}, 0);
        chk("bs_instr", if_id_instr, 0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("bs_addr", imem_addr, 32'h500);
        chk("bs_req", {31'd0, imem_req}, 1);

        // Wraparound at the top of the address space.
        set_pc(32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h77);
        chk("wr_npc", next_pc, 32'h0);
        tick();
        chk("wr_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wr_pc4", if_id_pc_plus4, 32'h0);

        // Asynchronous reset while draining.
        drive(1'b0, 1'b0, 1'b1, 32'h600, 32'h0);
        tick();
        branch_taken = 1'b0;
        chk("rd_addr_drain", imem_addr, 32'h0);
        #1 reset = 1'b0;
        #1;
        chk("rd_pc", if_id_pc, 0);
        chk("rd_pc4", if_id_pc_plus4, 0);
        chk("rd_req", {31'd0, imem_req}, 0);
        chk("rd_pcw", {31'd0, pc_write}, 0);
        @(posedge clock);
        @(negedge clock); reset = 1'b1; #1;
        chk("rd_rel_req", {31'd0, imem_req}, 1);
        chk("rd_rel_addr", imem_addr, 32'h600);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
